// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: source selects, load funct3 codes
// and the stage FSM states.
package wb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// Bundle between the memory-access stage, data memory read port and the
// register-file write port. in_valid/in_ready: a transfer happens on a rising
// edge where both are high; in_valid may not depend on in_ready.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic [1:0]      mem_to_reg;
    logic [2:0]      funct3;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_rvalid;
    logic            wb_valid;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_err;

    modport master (
        output in_valid, flush, mem_to_reg, funct3, reg_write, rd,
               alu_result, imm, pc, mem_rdata, mem_rvalid,
        input  in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_err
    );

    modport slave (
        input  in_valid, flush, mem_to_reg, funct3, reg_write, rd,
               alu_result, imm, pc, mem_rdata, mem_rvalid,
        output in_ready, wb_valid, wb_we, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/wb_stage_load_align.sv
// Combinational load formatter: picks the addressed lane of the memory word,
// sign/zero extends it, and flags misaligned or unsupported load sizes.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [2:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misalign,
    output logic            illegal
);
    localparam int LANE_W = (XLEN == 64) ? 3 : 2;

    logic [LANE_W-1:0] lane;
    logic [XLEN-1:0]   shifted;
    logic [7:0]        b_val;
    logic [15:0]       h_val;
    logic [31:0]       w_val;

    assign lane    = addr[LANE_W-1:0];
    assign shifted = mem_rdata >> {lane, 3'b000};
    assign b_val   = shifted[7:0];
    assign h_val   = shifted[15:0];
    assign w_val   = shifted[31:0];

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:  data = XLEN'(signed'(b_val));
            F3_LBU: data = XLEN'(b_val);
            F3_LH: begin
                data     = XLEN'(signed'(h_val));
                misalign = addr[0];
            end
            F3_LHU: begin
                data     = XLEN'(h_val);
                misalign = addr[0];
            end
            F3_LW: begin
                data     = XLEN'(signed'(w_val));
                misalign = (addr[1:0] != 2'b00);
            end
            // Doubleword and unsigned-word loads only exist on a 64-bit datapath.
            F3_LWU: begin
                data     = XLEN'(w_val);
                misalign = (addr[1:0] != 2'b00);
                illegal  = (XLEN != 64);
            end
            F3_LD: begin
                data     = shifted;
                misalign = (addr != 3'b000);
                illegal  = (XLEN != 64);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: selects ALU / load / PC+step / immediate, waits
// for late load data, and issues a one-cycle register-file write strobe.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    wb_stage_if.slave  bus,
    output wb_state_e  state_dbg
);
    wb_state_e state_q, state_d;

    logic [4:0] pend_rd_q, pend_rd_d;
    logic       pend_we_q, pend_we_d;
    logic [2:0] pend_f3_q, pend_f3_d;
    logic [2:0] pend_addr_q, pend_addr_d;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_we_q, wb_we_d;
    logic            wb_err_q, wb_err_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;

    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] pc_link;
    logic [XLEN-1:0] nonmem_val;

    logic [2:0]      al_f3;
    logic [2:0]      al_addr;
    logic [XLEN-1:0] al_data;
    logic            al_mis;
    logic            al_ill;

    logic            do_wb;
    logic [4:0]      src_rd;
    logic            src_we;
    logic [XLEN-1:0] src_data;
    logic            src_err;

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = bus.in_valid && in_ready;
    assign pc_link  = bus.pc + XLEN'(unsigned'(PC_STEP));

    always_comb begin
        case (bus.mem_to_reg)
            WB_PC:   nonmem_val = pc_link;
            WB_IMM:  nonmem_val = bus.imm;
            default: nonmem_val = bus.alu_result;
        endcase
    end

    // While waiting, the formatter must see the load that was accepted earlier.
    assign al_f3   = (state_q == LOAD_WAIT) ? pend_f3_q   : bus.funct3;
    assign al_addr = (state_q == LOAD_WAIT) ? pend_addr_q : bus.alu_result[2:0];

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .mem_rdata (bus.mem_rdata),
        .addr      (al_addr),
        .funct3    (al_f3),
        .data      (al_data),
        .misalign  (al_mis),
        .illegal   (al_ill)
    );

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        pend_we_d   = pend_we_q;
        pend_f3_d   = pend_f3_q;
        pend_addr_d = pend_addr_q;
        do_wb       = 1'b0;
        src_rd      = bus.rd;
        src_we      = bus.reg_write;
        src_data    = nonmem_val;
        src_err     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && !bus.flush) begin
                    if (bus.mem_to_reg == WB_MEM) begin
                        if (bus.mem_rvalid) begin
                            do_wb    = 1'b1;
                            src_data = al_data;
                            src_err  = al_mis || al_ill;
                        end else begin
                            state_d     = LOAD_WAIT;
                            pend_rd_d   = bus.rd;
                            pend_we_d   = bus.reg_write;
                            pend_f3_d   = bus.funct3;
                            pend_addr_d = bus.alu_result[2:0];
                        end
                    end else begin
                        do_wb = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                // Flush wins over data returning in the same cycle.
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.mem_rvalid) begin
                    state_d  = IDLE;
                    do_wb    = 1'b1;
                    src_rd   = pend_rd_q;
                    src_we   = pend_we_q;
                    src_data = al_data;
                    src_err  = al_mis || al_ill;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_valid_d = do_wb;
        wb_err_d   = do_wb && src_err;
        wb_we_d    = do_wb && src_we && (src_rd != 5'd0) && !src_err;
        wb_rd_d    = do_wb ? src_rd : wb_rd_q;
        wb_data_d  = wb_data_q;
        if (do_wb) begin
            wb_data_d = src_err ? '0 : src_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_rd_q   <= '0;
            pend_we_q   <= 1'b0;
            pend_f3_q   <= '0;
            pend_addr_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            pend_rd_q   <= pend_rd_d;
            pend_we_q   <= pend_we_d;
            pend_f3_q   <= pend_f3_d;
            pend_addr_q <= pend_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_we_q     <= wb_we_d;
            wb_err_q    <= wb_err_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_err   = wb_err_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign state_dbg    = state_q;

endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered writeback stage for the CPU datapath; the successor of the 4-way memory-to-register select. Each cycle it accepts one instruction's results. It selects the writeback source: ALU result, aligned/extended load data, PC+step, or immediate. It waits for multi-cycle memory reads and presents a registered register-file write with valid, flush and misalignment reporting. It sits between the memory-access stage and the register file.

## Interface
- XLEN, 32, datapath width; legal values are 32 and 64.
- PC_STEP, 4, increment added to pc for the link value.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- flush  in  1  discard the instruction accepted or pending this cycle.
- mem_to_reg  in  2  source select: 0 = ALU, 1 = MEM, 2 = PC+PC_STEP, 3 = IMM.
- funct3  in  3  load size and sign; used only when mem_to_reg = 1.
- reg_write  in  1  instruction writes rd.
- rd  in  5  destination register.
- alu_result  in  XLEN  ALU value; its low bits are the load address.
- imm  in  XLEN  immediate (LUI path).
- pc  in  XLEN  instruction PC.
- mem_rdata  in  XLEN  memory read word.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- wb_valid  out  1  one-cycle writeback strobe.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  destination register.
- wb_data  out  XLEN  writeback value.
- wb_err  out  1  one-cycle strobe for a misaligned or illegal load.

## Operation
- FSM states are IDLE and LOAD_WAIT. in_ready = (state == IDLE) and not rst.
- Accept condition: in_valid and in_ready. On accept, rd, reg_write, funct3, addr low bits, mem_to_reg and the selected non-memory value are captured.
- When mem_to_reg ≠ 1, or mem_to_reg = 1 with mem_rvalid high at accept, the result registers on that edge. The state stays IDLE.
- When mem_to_reg = 1 and mem_rvalid is low at accept, the state goes to LOAD_WAIT. The first cycle with mem_rvalid high completes the load and returns to IDLE. There is no timeout.
- Load alignment uses addr = alu_result[2:0]. Byte lane = mem_rdata >> (8 × addr[log2(XLEN/8)-1:0]).
  - 000 LB: sign-extend 8 bits.
  - 001 LH: sign-extend 16 bits.
  - 010 LW: sign-extend 32 bits.
  - 100 LBU: zero-extend 8 bits.
  - 101 LHU: zero-extend 16 bits.
  - 011 LD and 110 LWU: legal only when XLEN = 64.
- Misaligned load: LH/LHU with addr[0] ≠ 0, LW/LWU with addr[1:0] ≠ 0, or LD with addr[2:0] ≠ 0.
- A misaligned load or an illegal funct3 still completes normally, with wb_valid = 1, wb_we = 0, wb_data = 0 and wb_err = 1.
- The PC path computes pc + PC_STEP modulo 2^XLEN; wrap-around is silent.
- wb_we = reg_write and (rd ≠ 0) and no error. rd = 0 never writes, but wb_valid still pulses.
- Flush while in IDLE: an instruction accepted in the same cycle is dropped, and wb_valid is 0 next cycle.
- Flush while in LOAD_WAIT: the state returns to IDLE and nothing is written. If mem_rvalid is high in the same cycle as the flush, it is ignored.
- Flush with in_valid in IDLE: the stage is not stalled, but the instruction is discarded.

## Timing
- Reset values: state = IDLE, wb_valid = 0, wb_we = 0, wb_rd = 0, wb_data = 0, wb_err = 0. in_ready = 0 while rst is high and 1 on the first cycle after release.
- Latency: 1 cycle from accept to wb_valid for non-loads and for loads that are ready at accept. For a load whose mem_rvalid arrives k cycles after accept, latency is k + 1.
- wb_valid, wb_we and wb_err are single-cycle pulses. wb_rd and wb_data hold their values until the next writeback.
- Throughput is one instruction per cycle back-to-back while no load wait occurs.
- A mem_rvalid arriving in IDLE with no load accepted is ignored.
- rst asserted in LOAD_WAIT aborts immediately; the pending load is never written.

## Structure
- Shared package wb_pkg contains:
  - mem_to_reg encodings: WB_ALU, WB_MEM, WB_PC, WB_IMM.
  - funct3 load encodings.
  - The state enum (IDLE, LOAD_WAIT).
- Sub-module load_align is combinational. Its inputs are mem_rdata, addr, funct3 and XLEN. Its outputs are the extended data, misalign and illegal.

## Test plan
- Reset then a single instruction per select: XLEN = 32, alu_result = 15, mem_rdata = 20 with mem_rvalid = 1, pc = 4, imm = 0x1000, rd = 5.
  - Sequence mem_to_reg 0, 1, 2, 3 → wb_data = 15, 20, 8, 0x1000.
  - Each has wb_valid and wb_we for exactly 1 cycle.
- Loads with mem_rdata = 0x80FF7F01 and mem_rvalid = 1:
  - LB at addr 3 → 0xFFFFFF80.
  - LBU at addr 1 → 0x0000007F.
  - LH at addr 2 → 0xFFFF80FF.
  - LHU at addr 0 → 0x00007F01.
- Wait state: LW accepted with mem_rvalid = 0, then mem_rvalid = 1 three cycles later.
  - in_ready stays 0 for 3 cycles.
  - wb_valid fires 4 cycles after accept.
- Flush in LOAD_WAIT together with mem_rvalid = 1 → no wb_valid, and in_ready = 1 next cycle.
- Misaligned LW at addr 2 → wb_valid = 1, wb_we = 0, wb_err = 1. Also, a write with rd = 0 gives wb_we = 0.
- XLEN = 64:
  - LD at addr 0 with mem_rdata = 0x8000000000000001 → that value unchanged.
  - LWU at addr 4 → 0x0000000080000000.
  - pc = 0xFFFFFFFFFFFFFFFC with the PC select → wb_data = 0.
